// File: rtl/udp_reg_pkg.sv
// rtl/udp_reg_pkg.sv - shared types and constants for the UDP register-write receiver
package udp_reg_pkg;

  typedef enum logic [2:0] {
    HDR,
    PAYLOAD,
    DRAIN,
    COMMIT,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MAGIC = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_LEN   = 2'd3
  } err_t;

  // Byte offsets inside the 4-byte frame header
  localparam int HDR_MAGIC = 0;
  localparam int HDR_ADDR  = 1;
  localparam int HDR_COUNT = 2;
  localparam int HDR_RSVD  = 3;
  localparam int HDR_BYTES = 4;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/udp_byte_packer.sv
// rtl/udp_byte_packer.sv - assembles a byte stream into DATA_W-bit words
module udp_byte_packer #(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);
  localparam int         BPW  = DATA_W / 8;
  localparam logic [3:0] LAST = 4'(BPW - 1);

  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] acc_q;

  // Word including the byte currently offered, so the word is usable on its final byte
  always_comb begin
    word = acc_q;
    if (BIG_ENDIAN != 0) begin
      word = DATA_W'({acc_q, byte_data});
    end else begin
      word[int'(cnt_q)*8 +: 8] = byte_data;
    end
    word_done = byte_valid && (cnt_q == LAST);
  end

  // Byte position and partial word; clear restarts alignment for a new frame
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cnt_q <= 4'd0;
      acc_q <= '0;
    end else if (byte_valid) begin
      acc_q <= word;
      cnt_q <= word_done ? 4'd0 : cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/udp_reg_frame_rx.sv
// rtl/udp_reg_frame_rx.sv - UDP register-write frame receiver with atomic range commit
module udp_reg_frame_rx
  import udp_reg_pkg::*;
#(
  parameter int         NREGS      = 16,
  parameter int         DATA_W     = 32,
  parameter int         BIG_ENDIAN = 1,
  parameter logic [7:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rx_tvalid,
  output logic                    rx_tready,
  input  logic [7:0]              rx_tdata,
  input  logic                    rx_tlast,
  input  logic                    rx_tuser,
  output logic [NREGS*DATA_W-1:0] wr_val,
  output logic [NREGS-1:0]        wr_stb,
  output logic                    dv_out,
  output logic                    err_out,
  output logic [1:0]              err_code,
  output logic [15:0]             good_cnt,
  output logic [15:0]             bad_cnt
);
  state_t            state_q, state_d;
  err_t              pend_q, pend_d;
  logic [1:0]        hdr_idx_q;
  logic [7:0]        magic_q, addr_q, count_q, word_idx_q;
  logic [8:0]        wr_idx, range_end;
  logic              beat, pk_valid, pk_clear, word_done, last_byte;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] shadow [NREGS];

  assign beat      = rx_tvalid && rx_tready;
  assign pk_valid  = beat && (state_q == PAYLOAD);
  assign pk_clear  = (state_q != PAYLOAD);
  assign wr_idx    = {1'b0, addr_q} + {1'b0, word_idx_q};
  assign range_end = {1'b0, addr_q} + {1'b0, count_q};
  assign last_byte = word_done && (word_idx_q == count_q - 8'd1);

  udp_byte_packer #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (rx_tdata),
    .word       (word),
    .word_done  (word_done)
  );

  // Next-state decode; pend_d remembers the first failure seen before draining
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      HDR: begin
        if (beat) begin
          if (rx_tlast || rx_tuser) begin
            state_d = ERR;
          end else if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
            if (magic_q != MAGIC) begin
              state_d = DRAIN;
              pend_d  = ERR_MAGIC;
            end else if (count_q == 8'd0 || range_end > 9'(NREGS)) begin
              state_d = DRAIN;
              pend_d  = ERR_RANGE;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        if (beat) begin
          if (rx_tlast) begin
            state_d = (last_byte && !rx_tuser) ? COMMIT : ERR;
          end else if (last_byte || rx_tuser) begin
            state_d = DRAIN;
            pend_d  = ERR_LEN;
          end
        end
      end
      DRAIN: begin
        if (beat && rx_tlast) state_d = ERR;
      end
      default: state_d = HDR;
    endcase
  end

  // Word completions land in the shadow bank; only the committed range is ever read
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREGS; k++) begin
      if (word_done && int'(wr_idx) == k) shadow[k] <= word;
    end
  end

  // FSM state, header capture, and registered commit/error outputs aligned to COMMIT/ERR
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= HDR;
      pend_q     <= ERR_NONE;
      rx_tready  <= 1'b0;
      hdr_idx_q  <= 2'd0;
      magic_q    <= 8'd0;
      addr_q     <= 8'd0;
      count_q    <= 8'd0;
      word_idx_q <= 8'd0;
      wr_val     <= '0;
      wr_stb     <= '0;
      dv_out     <= 1'b0;
      err_out    <= 1'b0;
      err_code   <= 2'd0;
      good_cnt   <= 16'd0;
      bad_cnt    <= 16'd0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      rx_tready <= (state_d == HDR) || (state_d == PAYLOAD) || (state_d == DRAIN);
      wr_stb    <= '0;
      dv_out    <= 1'b0;
      err_out   <= 1'b0;

      if (state_q != HDR) hdr_idx_q <= 2'd0;
      else if (beat)      hdr_idx_q <= hdr_idx_q + 2'd1;

      if (state_q == HDR && beat) begin
        case (hdr_idx_q)
          2'(HDR_MAGIC): magic_q <= rx_tdata;
          2'(HDR_ADDR):  addr_q  <= rx_tdata;
          2'(HDR_COUNT): count_q <= rx_tdata;
          2'(HDR_RSVD):  ;
          default:       ;
        endcase
      end

      if (state_q != PAYLOAD) word_idx_q <= 8'd0;
      else if (word_done)     word_idx_q <= word_idx_q + 8'd1;

      // The final word is still in flight to the shadow, so it is taken from the packer
      if (state_d == COMMIT) begin
        for (int k = 0; k < NREGS; k++) begin
          if (k >= int'(addr_q) && k < int'(range_end)) begin
            wr_val[k*DATA_W +: DATA_W] <= (int'(wr_idx) == k) ? word : shadow[k];
            wr_stb[k] <= 1'b1;
          end
        end
        dv_out <= 1'b1;
        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      end

      if (state_d == ERR) begin
        err_out  <= 1'b1;
        err_code <= (state_q == DRAIN) ? pend_q : ERR_LEN;
        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_reg_frame_rx.sv
// tb/tb_udp_reg_frame_rx.sv - randomized self-checking bench for udp_reg_frame_rx
module tb_udp_reg_frame_rx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tvalid;
  logic [7:0]  tdata;
  logic        tlast;
  logic        tuser;
  logic        sel;
  logic        v1, v2, rdy1, rdy2;
  logic [511:0] wr_val1;
  logic [15:0]  wr_stb1;
  logic [63:0]  wr_val2;
  logic [3:0]   wr_stb2;
  logic        dv1, dv2, er1, er2;
  logic [1:0]  code1, code2;
  logic [15:0] good1, good2, bad1, bad2;

  logic         obs_rdy, obs_dv, obs_err;
  logic [511:0] obs_val;
  logic [15:0]  obs_stb, obs_good, obs_bad;
  logic [1:0]   obs_code;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  fb[$];
  bit          fu[$];
  logic [31:0] exp_bank [2][16];
  logic [15:0] exp_good [2];
  logic [15:0] exp_bad  [2];
  logic [1:0]  exp_code [2];
  logic [15:0] exp_stb;
  logic        exp_dv, exp_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v1 = tvalid && !sel;
  assign v2 = tvalid && sel;

  udp_reg_frame_rx u_dut (
    .clk(clk), .resetn(resetn), .rx_tvalid(v1), .rx_tready(rdy1), .rx_tdata(tdata),
    .rx_tlast(tlast), .rx_tuser(tuser), .wr_val(wr_val1), .wr_stb(wr_stb1), .dv_out(dv1),
    .err_out(er1), .err_code(code1), .good_cnt(good1), .bad_cnt(bad1)
  );

  udp_reg_frame_rx #(.NREGS(4), .DATA_W(16), .BIG_ENDIAN(0)) u_dut_p (
    .clk(clk), .resetn(resetn), .rx_tvalid(v2), .rx_tready(rdy2), .rx_tdata(tdata),
    .rx_tlast(tlast), .rx_tuser(tuser), .wr_val(wr_val2), .wr_stb(wr_stb2), .dv_out(dv2),
    .err_out(er2), .err_code(code2), .good_cnt(good2), .bad_cnt(bad2)
  );

  // View of whichever instance is currently selected
  always_comb begin
    obs_rdy  = sel ? rdy2 : rdy1;
    obs_val  = sel ? 512'(wr_val2) : wr_val1;
    obs_stb  = sel ? 16'(wr_stb2) : wr_stb1;
    obs_dv   = sel ? dv2 : dv1;
    obs_err  = sel ? er2 : er1;
    obs_code = sel ? code2 : code1;
    obs_good = sel ? good2 : good1;
    obs_bad  = sel ? bad2 : bad1;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nregs_f();
    return sel ? 4 : 16;
  endfunction

  function automatic int bpw_f();
    return sel ? 2 : 4;
  endfunction

  function automatic logic [511:0] exp_vec();
    logic [511:0] v = '0;
    for (int k = 0; k < nregs_f(); k++) v = v | (512'(exp_bank[sel][k]) << (k * bpw_f() * 8));
    return v;
  endfunction

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 16; k++) exp_bank[s][k] = 32'd0;
      exp_good[s] = 16'd0;
      exp_bad[s]  = 16'd0;
      exp_code[s] = 2'd0;
    end
  endtask

  // Frame-level reference: decide the outcome from the frame rules, then apply it
  task automatic model_apply();
    int L, code, a, n, bpw, sh;
    logic [31:0] w32;
    L    = fb.size();
    code = 0;
    a    = 0;
    n    = 0;
    bpw  = bpw_f();
    for (int i = 0; i < 4 && i < L; i++)
      if (code == 0 && (fu[i] || i == L - 1)) code = 3;
    if (code == 0) begin
      a = int'(fb[1]);
      n = int'(fb[2]);
      if (fb[0] != 8'hA5) code = 1;
      else if (n == 0 || a + n > nregs_f()) code = 2;
      else begin
        if (L - 4 != n * bpw) code = 3;
        for (int i = 4; i < L; i++) if (fu[i]) code = 3;
      end
    end
    exp_stb = '0;
    if (code == 0) begin
      for (int w = 0; w < n; w++) begin
        w32 = 32'd0;
        for (int i = 0; i < bpw; i++) begin
          sh  = sel ? 8 * i : 8 * (bpw - 1 - i);
          w32 = w32 | (32'(fb[4 + w*bpw + i]) << sh);
        end
        exp_bank[sel][a + w] = w32;
        exp_stb[a + w] = 1'b1;
      end
      exp_dv  = 1'b1;
      exp_err = 1'b0;
      if (exp_good[sel] != 16'hFFFF) exp_good[sel] = exp_good[sel] + 16'd1;
    end else begin
      exp_dv  = 1'b0;
      exp_err = 1'b1;
      exp_code[sel] = 2'(code);
      if (exp_bad[sel] != 16'hFFFF) exp_bad[sel] = exp_bad[sel] + 16'd1;
    end
  endtask

  // Entered and left just after a rising edge
  task automatic send_byte(input logic [7:0] d, input bit last, input bit user,
                           input int gap, output int bc);
    int n = 0;
    while (gap > 0 && $urandom_range(99) < gap) begin
      tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    tuser  = user;
    @(negedge clk);
    while (!obs_rdy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!obs_rdy) chk("rdy_timeout", 0, 1);
    @(posedge clk);
    #1;
    bc     = cyc;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic check_post(input string tag);
    @(negedge clk);
    chk({tag, "_dv"},   obs_dv,   exp_dv);
    chk({tag, "_err"},  obs_err,  exp_err);
    chk({tag, "_stb"},  obs_stb,  exp_stb);
    chk({tag, "_code"}, obs_code, exp_code[sel]);
    chk({tag, "_good"}, obs_good, exp_good[sel]);
    chk({tag, "_bad"},  obs_bad,  exp_bad[sel]);
    chk({tag, "_bank"}, obs_val,  exp_vec());
    @(negedge clk);
    chk({tag, "_dv_clr"},  obs_dv,  0);
    chk({tag, "_err_clr"}, obs_err, 0);
    chk({tag, "_stb_clr"}, obs_stb, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string tag, input bit do_chk, input int gap,
                            output int first, output int last);
    int bc = 0;
    first = 0;
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], i == fb.size() - 1, fu[i], gap, bc);
      if (i == 0) first = bc;
    end
    last = bc;
    model_apply();
    if (do_chk) check_post(tag);
  endtask

  task automatic hdr(input logic [7:0] m, input logic [7:0] a, input logic [7:0] n);
    fb.delete();
    fu.delete();
    fb.push_back(m); fb.push_back(a); fb.push_back(n); fb.push_back(8'h00);
    repeat (4) fu.push_back(1'b0);
  endtask

  task automatic pay(input int cnt, input logic [7:0] start);
    for (int i = 0; i < cnt; i++) begin
      fb.push_back(8'(int'(start) + i));
      fu.push_back(1'b0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},  obs_rdy,  0);
    chk({tag, "_val"},  obs_val,  0);
    chk({tag, "_stb"},  obs_stb,  0);
    chk({tag, "_dv"},   obs_dv,   0);
    chk({tag, "_err"},  obs_err,  0);
    chk({tag, "_code"}, obs_code, 0);
    chk({tag, "_good"}, obs_good, 0);
    chk({tag, "_bad"},  obs_bad,  0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1, l1, f2, l2, len, a, n, gap, bc;
    logic [7:0] mg;
    resetn = 1'b0;
    tvalid = 1'b0;
    tdata  = 8'h00;
    tlast  = 1'b0;
    tuser  = 1'b0;
    sel    = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_zero("reset0");
    sel = 1'b1;
    #1;
    chk_zero("reset1");
    sel = 1'b0;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Full-bank good frame
    hdr(8'hA5, 8'h00, 8'h10); pay(64, 8'h01);
    send_frame("full", 1, 0, f1, l1);
    chk("full_reg0",  obs_val[31:0],    32'h01020304);
    chk("full_reg15", obs_val[511:480], 32'h3D3E3F40);

    // Partial range
    hdr(8'hA5, 8'h03, 8'h02); pay(8, 8'h11);
    send_frame("part", 1, 0, f1, l1);
    chk("part_reg3", obs_val[127:96],  32'h11121314);
    chk("part_reg4", obs_val[159:128], 32'h15161718);

    // Error frames
    hdr(8'h5A, 8'h00, 8'h01); pay(4, 8'h20);
    send_frame("magic", 1, 0, f1, l1);
    hdr(8'hA5, 8'h0F, 8'h02); pay(8, 8'h30);
    send_frame("range", 1, 0, f1, l1);
    hdr(8'hA5, 8'h00, 8'h02); pay(7, 8'h40);
    send_frame("short", 1, 0, f1, l1);
    hdr(8'hA5, 8'h00, 8'h04); pay(16, 8'h50); fu[10] = 1'b1;
    send_frame("tuser", 1, 0, f1, l1);

    // Throttled good frame
    hdr(8'hA5, 8'h00, 8'h10); pay(64, 8'h01);
    send_frame("gaps", 1, 50, f1, l1);

    // Back-to-back frames
    hdr(8'hA5, 8'h03, 8'h02); pay(8, 8'h61);
    send_frame("b2b_a", 0, 0, f1, l1);
    hdr(8'hA5, 8'h05, 8'h01); pay(4, 8'h71);
    send_frame("b2b_b", 1, 0, f2, l2);
    chk("b2b_gap", f2 - l1, 2);

    // Reset in the middle of a payload
    hdr(8'hA5, 8'h00, 8'h04); pay(16, 8'h01);
    for (int i = 0; i < 10; i++) send_byte(fb[i], 1'b0, 1'b0, 0, bc);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    @(posedge clk);
    #1;
    reset_model();
    repeat (10) begin
      void'(fb.pop_front());
      void'(fu.pop_front());
    end
    send_frame("rst_rem", 1, 0, f1, l1);
    hdr(8'hA5, 8'h02, 8'h03); pay(12, 8'h81);
    send_frame("rst_good", 1, 0, f1, l1);

    // Narrow little-endian instance
    sel = 1'b1;
    #1;
    hdr(8'hA5, 8'h00, 8'h01); pay(2, 8'h01);
    send_frame("p_le", 1, 0, f1, l1);
    chk("p_le_reg0", obs_val[15:0], 16'h0201);
    hdr(8'hA5, 8'h03, 8'h01); fb.push_back(8'hAA); fb.push_back(8'hBB);
    fu.push_back(1'b0); fu.push_back(1'b0);
    send_frame("p_top", 1, 0, f1, l1);
    chk("p_top_reg3", obs_val[63:48], 16'hBBAA);

    // Random frames on both instances
    for (int t = 0; t < 40; t++) begin
      sel = 1'($urandom_range(1));
      #1;
      mg  = ($urandom_range(7) == 0) ? 8'h5A : 8'hA5;
      a   = $urandom_range(nregs_f() + 1);
      n   = $urandom_range(5);
      len = 4 + n * bpw_f();
      case ($urandom_range(9))
        0: len = len - 1;
        1: len = len + 1;
        2: len = $urandom_range(4, 1);
        default: ;
      endcase
      if (len < 1) len = 1;
      fb.delete();
      fu.delete();
      for (int i = 0; i < len; i++) begin
        if (i == 0)      fb.push_back(mg);
        else if (i == 1) fb.push_back(8'(a));
        else if (i == 2) fb.push_back(8'(n));
        else             fb.push_back(8'($urandom_range(255)));
        fu.push_back(i >= 4 && $urandom_range(15) == 0);
      end
      gap = ($urandom_range(1) == 1) ? 50 : 0;
      send_frame("rand", 1, gap, f1, l1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
